// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: issues eight word reads for a missed block,
// writes returned words in arrival order, then writes the tag entry.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        mem_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        write_tag_array,
    output logic [11:0] fill_tag
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] TAG  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [11:0] blk_q, blk_d;
    logic [3:0]  issue_q, issue_d;
    logic [3:0]  recv_q, recv_d;
    logic        in_fill;

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        issue_d = issue_q;
        recv_d  = recv_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d = FILL;
                    blk_d   = miss_address[15:4];
                    issue_d = 4'd0;
                    recv_d  = 4'd0;
                end
            end
            FILL: begin
                if (!issue_q[3]) begin
                    issue_d = issue_q + 4'd1;
                end
                // Returns are counted independently of issue progress
                if (memory_data_valid) begin
                    recv_d = recv_q + 4'd1;
                    if (recv_q == 4'd7) begin
                        state_d = TAG;
                    end
                end
            end
            TAG: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            blk_q   <= 12'd0;
            issue_q <= 4'd0;
            recv_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
        end
    end

    assign in_fill          = (state_q == FILL);
    assign fsm_busy         = (state_q != IDLE);
    assign mem_en           = in_fill && !issue_q[3];
    assign memory_address   = mem_en ? {blk_q, issue_q[2:0], 1'b0}
                                     : {blk_q, 4'b0000};
    assign write_data_array = in_fill && memory_data_valid;
    assign fill_word        = in_fill ? recv_q[2:0] : 3'd0;
    assign fill_data        = in_fill ? memory_data : 16'd0;
    assign write_tag_array  = (state_q == TAG);
    assign fill_tag         = blk_q;

endmodule
